z_event_counter: RTL and testbench

//  Downstream monitor for the binary-encoded sequence-detector FSM. Samples the

---
 rtl/z_event_counter.sv | 105 ++++++++++
 tb/tb_z_event_counter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/z_event_counter.sv
// Statistics monitor for a sequence detector: counts z rising edges, tracks z-high
// run lengths, records the state at each detection and flags illegal encodings.
module z_event_counter #(
    parameter int unsigned COUNT_W = 8,
    parameter int unsigned RUN_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               z,
    input  logic [2:0]         state,
    input  logic               clear,
    input  logic               freeze,
    output logic               z_rise,
    output logic [COUNT_W-1:0] count,
    output logic               overflow,
    output logic [RUN_W-1:0]   run_len,
    output logic [RUN_W-1:0]   max_run,
    output logic [2:0]         last_state,
    output logic               illegal_state
);

    localparam logic [2:0] LastLegal = 3'b100;

    logic               z_q;
    logic               z_rise_q, z_rise_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [RUN_W-1:0]   run_len_q, run_len_d;
    logic [RUN_W-1:0]   max_run_q, max_run_d;
    logic [2:0]         last_state_q, last_state_d;
    logic               illegal_q, illegal_d;
    logic               rise;

    assign rise = z & ~z_q;

    always_comb begin
        z_rise_d     = rise;
        count_d      = count_q;
        overflow_d   = overflow_q;
        run_len_d    = run_len_q;
        max_run_d    = max_run_q;
        last_state_d = last_state_q;
        illegal_d    = illegal_q;

        if (clear) begin
            count_d      = '0;
            overflow_d   = 1'b0;
            run_len_d    = '0;
            max_run_d    = '0;
            last_state_d = 3'b000;
            illegal_d    = 1'b0;
        end else if (!freeze) begin
            if (rise) begin
                if (count_q != {COUNT_W{1'b1}}) begin
                    count_d = count_q + COUNT_W'(1);
                end else begin
                    overflow_d = 1'b1;
                end
                last_state_d = state;
                run_len_d    = RUN_W'(1);
            end else if (z && (run_len_q != {RUN_W{1'b1}})) begin
                run_len_d = run_len_q + RUN_W'(1);
            end
            // Compare against the updated run length so max tracks in the same cycle.
            if (run_len_d > max_run_q) begin
                max_run_d = run_len_d;
            end
            if (state > LastLegal) begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z_q          <= 1'b0;
            z_rise_q     <= 1'b0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            run_len_q    <= '0;
            max_run_q    <= '0;
            last_state_q <= 3'b000;
            illegal_q    <= 1'b0;
        end else begin
            // Edge tracking runs even under clear/freeze so unfreeze cannot fake a rise.
            z_q          <= z;
            z_rise_q     <= z_rise_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            run_len_q    <= run_len_d;
            max_run_q    <= max_run_d;
            last_state_q <= last_state_d;
            illegal_q    <= illegal_d;
        end
    end

    assign z_rise        = z_rise_q;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign run_len       = run_len_q;
    assign max_run       = max_run_q;
    assign last_state    = last_state_q;
    assign illegal_state = illegal_q;

endmodule

// File: tb/tb_z_event_counter.sv
// Directed vector table plus hand sequences and a random stream checked against a model.
module tb_z_event_counter;

    logic       clk = 1'b0;
    logic       reset, z, clear, freeze;
    logic [2:0] state;

    logic       z_rise, overflow, illegal_state;
    logic [7:0] count;
    logic [3:0] run_len, max_run;
    logic [2:0] last_state;

    logic       z_rise3, overflow3, illegal3;
    logic [2:0] count3;
    logic [3:0] run_len3, max_run3;
    logic [2:0] last_state3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    z_event_counter dut (
        .clk(clk), .reset(reset), .z(z), .state(state), .clear(clear), .freeze(freeze),
        .z_rise(z_rise), .count(count), .overflow(overflow), .run_len(run_len),
        .max_run(max_run), .last_state(last_state), .illegal_state(illegal_state)
    );

    z_event_counter #(.COUNT_W(3), .RUN_W(4)) dut3 (
        .clk(clk), .reset(reset), .z(z), .state(state), .clear(clear), .freeze(freeze),
        .z_rise(z_rise3), .count(count3), .overflow(overflow3), .run_len(run_len3),
        .max_run(max_run3), .last_state(last_state3), .illegal_state(illegal3)
    );

    typedef struct {
        logic       z;
        logic [2:0] st;
        logic       clr;
        logic       frz;
        logic       e_rise;
        int         e_cnt;
        int         e_run;
        int         e_max;
        int         e_last;
        logic       e_ill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic zi, input logic [2:0] si, input logic ci, input logic fi);
        z = zi; state = si; clear = ci; freeze = fi;
        step();
    endtask

    int m_cnt, m_run, m_max, m_rise;
    logic m_zq;

    initial begin
        reset = 1'b1; z = 1'b0; state = 3'b000; clear = 1'b0; freeze = 1'b0;
        step();
        step();
        chk("reset z_rise", int'(z_rise), 0);
        chk("reset count", int'(count), 0);
        chk("reset overflow", int'(overflow), 0);
        chk("reset run_len", int'(run_len), 0);
        chk("reset max_run", int'(max_run), 0);
        chk("reset last_state", int'(last_state), 0);
        chk("reset illegal", int'(illegal_state), 0);
        reset = 1'b0;

        // z st clr frz | rise cnt run max last ill
        vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0});
        vecs.push_back('{1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1, 1, 1, 1, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1, 2, 2, 1, 1'b0});
        vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1, 3, 3, 1, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1, 3, 3, 1, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0});
        // runs of 2, 5 and 1 cycles
        vecs.push_back('{1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1, 1, 1, 1, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1, 2, 2, 1, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1, 2, 2, 1, 1'b0});
        vecs.push_back('{1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 2, 1, 2, 4, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 2, 2, 2, 4, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 2, 3, 3, 4, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 2, 4, 4, 4, 1'b0});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 2, 5, 5, 4, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2, 5, 5, 4, 1'b0});
        vecs.push_back('{1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 3, 1, 5, 2, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3, 1, 5, 2, 1'b0});
        // clear coincident with a rise: pulse still shows, rise not counted
        vecs.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0});
        vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1, 1, 1, 3, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1, 1, 1, 3, 1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].z, vecs[i].st, vecs[i].clr, vecs[i].frz);
            chk($sformatf("vec%0d z_rise", i), int'(z_rise), int'(vecs[i].e_rise));
            chk($sformatf("vec%0d count", i), int'(count), vecs[i].e_cnt);
            chk($sformatf("vec%0d run_len", i), int'(run_len), vecs[i].e_run);
            chk($sformatf("vec%0d max_run", i), int'(max_run), vecs[i].e_max);
            chk($sformatf("vec%0d last_state", i), int'(last_state), vecs[i].e_last);
            chk($sformatf("vec%0d illegal", i), int'(illegal_state), int'(vecs[i].e_ill));
        end

        // Saturation and overflow on the 3-bit counter instance
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 3'd2, 1'b0, 1'b0);
            chk($sformatf("sat rise%0d count3", i), int'(count3), (i < 7) ? i : 7);
            chk($sformatf("sat rise%0d overflow3", i), int'(overflow3), (i >= 8) ? 1 : 0);
            drive(1'b0, 3'd0, 1'b0, 1'b0);
        end
        chk("sat wide count", int'(count), 9);
        chk("sat wide overflow", int'(overflow), 0);
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        chk("sat clear count3", int'(count3), 0);
        chk("sat clear overflow3", int'(overflow3), 0);

        // Freeze across a run
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        chk("frz pre run_len", int'(run_len), 2);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd7, 1'b0, 1'b1);
            chk("frz hold run_len", int'(run_len), 2);
            chk("frz hold z_rise", int'(z_rise), 0);
            chk("frz hold illegal", int'(illegal_state), 0);
        end
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        chk("unfrz count", int'(count), 1);
        chk("unfrz run_len", int'(run_len), 3);
        chk("unfrz max_run", int'(max_run), 3);
        chk("unfrz z_rise", int'(z_rise), 0);
        // Rise that happens entirely inside a freeze window is never counted
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        drive(1'b1, 3'd4, 1'b0, 1'b1);
        chk("frz rise pulse", int'(z_rise), 1);
        chk("frz rise count", int'(count), 1);
        drive(1'b1, 3'd4, 1'b0, 1'b0);
        chk("frz rise unfrz count", int'(count), 1);
        chk("frz rise unfrz last", int'(last_state), 1);
        chk("frz rise unfrz run", int'(run_len), 4);

        // Illegal state sticky flag
        drive(1'b0, 3'd6, 1'b0, 1'b0);
        chk("illegal set", int'(illegal_state), 1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'd0, 1'b0, 1'b0);
            chk("illegal sticky", int'(illegal_state), 1);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("illegal after reset", int'(illegal_state), 0);
        chk("count after reset", int'(count), 0);
        drive(1'b0, 3'd5, 1'b0, 1'b0);
        chk("illegal 101", int'(illegal_state), 1);
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        chk("illegal clear", int'(illegal_state), 0);

        // Random stream against a reference model (state after clear above is all zero)
        m_cnt = 0; m_run = 0; m_max = 0; m_zq = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic rz, rc, rf;
            rz = ($urandom_range(0, 99) < 30) ? ~z : z;
            rc = ($urandom_range(0, 99) < 3);
            rf = ($urandom_range(0, 99) < 10);
            m_rise = (rz && !m_zq) ? 1 : 0;
            if (rc) begin
                m_cnt = 0; m_run = 0; m_max = 0;
            end else if (!rf) begin
                if (m_rise == 1) begin
                    if (m_cnt < 255) m_cnt++;
                    m_run = 1;
                end else if (rz && m_run < 15) begin
                    m_run++;
                end
                if (m_run > m_max) m_max = m_run;
            end
            m_zq = rz;
            drive(rz, 3'($urandom_range(0, 4)), rc, rf);
            chk("rand z_rise", int'(z_rise), m_rise);
            chk("rand count", int'(count), m_cnt);
            chk("rand run_len", int'(run_len), m_run);
            chk("rand max_run", int'(max_run), m_max);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
